// File: rtl/fp_result_collector_if.sv
// fp_result_collector_if: issue/result/consumer signals between the FP pipeline,
// its result collector and the downstream consumer.
interface fp_result_collector_if #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic             issue_in;
    logic             can_issue;
    logic             res_valid;
    logic [31:0]      res_data;
    logic             res_invalid;
    logic             res_overflow;
    logic             res_underflow;
    logic             res_inexact;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [3:0]       out_flags;
    logic [3:0]       sticky_flags;
    logic             flags_clear;
    logic [CNT_W-1:0] count;
    logic             err;

    modport master (
        output issue_in, res_valid, res_data, res_invalid, res_overflow, res_underflow,
               res_inexact, out_ready, flags_clear,
        input  can_issue, out_valid, out_data, out_flags, sticky_flags, count, err
    );

    modport slave (
        input  issue_in, res_valid, res_data, res_invalid, res_overflow, res_underflow,
               res_inexact, out_ready, flags_clear,
        output can_issue, out_valid, out_data, out_flags, sticky_flags, count, err
    );
endinterface

// File: rtl/fp_result_collector.sv
// fp_result_collector: result FIFO, sticky fflags and credit-based issue control for a non-stalling FP pipeline.
// Optional FP_COLLECT_BYPASS_EN forwards a result straight to the consumer when the FIFO is empty.
module fp_result_collector #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic                 clk,
    input logic                 rst_n,
    fp_result_collector_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [35:0]      mem [DEPTH];
    logic [35:0]      head;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, inflight;
    logic [CNT_W:0]   credit_sum;
    logic [3:0]       sticky, res_flags;
    logic             err, empty, full, pop, push, wr_en, drop, bypass;
    logic             underflow, over_issue, can_issue, inc, dec;

    assign res_flags  = {bus.res_invalid, bus.res_overflow, bus.res_underflow, bus.res_inexact};
    assign empty      = count == '0;
    assign full       = count == CNT_W'(DEPTH);
`ifdef FP_COLLECT_BYPASS_EN
    assign bypass     = empty & bus.res_valid & bus.out_ready;
`else
    assign bypass     = 1'b0;
`endif
    assign pop        = !empty & bus.out_ready;
    assign push       = bus.res_valid & !bypass;
    assign wr_en      = push & (!full | pop);
    assign drop       = push & full & !pop;
    assign credit_sum = {1'b0, count} + {1'b0, inflight};
    assign can_issue  = credit_sum < (CNT_W+1)'(DEPTH);
    assign inc        = bus.issue_in & !bus.res_valid;
    assign dec        = bus.res_valid & !bus.issue_in;
    assign underflow  = dec & (inflight == '0);
    assign over_issue = bus.issue_in & !can_issue;
    assign head       = mem[rd_ptr];

    // Outputs read as zero while empty so reset and idle present a clean bus
    assign bus.out_valid    = !empty | bypass;
    assign bus.out_data     = bypass ? bus.res_data : (empty ? 32'h0 : head[31:0]);
    assign bus.out_flags    = bypass ? res_flags : (empty ? 4'h0 : head[35:32]);
    assign bus.can_issue    = can_issue;
    assign bus.count        = count;
    assign bus.sticky_flags = sticky;
    assign bus.err          = err;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {res_flags, bus.res_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            sticky   <= '0;
            err      <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en & !pop) count <= count + CNT_W'(1);
            else if (pop & !wr_en) count <= count - CNT_W'(1);
            // Saturate both ways so repeated protocol abuse cannot wrap the credit count
            if (inc & (inflight != '1)) inflight <= inflight + CNT_W'(1);
            else if (dec & !underflow) inflight <= inflight - CNT_W'(1);
            sticky <= (bus.flags_clear ? 4'h0 : sticky) | (bus.res_valid ? res_flags : 4'h0);
            err    <= err | drop | underflow | over_issue;
        end
    end
endmodule
